// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the in-order RV32 pipeline.
// Keeps the fetch PC and predicts not-taken (PC+4). It issues requests on the
// instruction-memory port, buffers in-flight responses so that a decode stall
// never drops an instruction, and presents one instruction per cycle to decode.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   stage_ctrl_i          .stall holds the output register, .squash invalidates the entry being loaded
//   redirect_i/_pc_i      execute-stage redirect and its target (low two bits ignored)
//   imem_req_o/addr_o     request valid and fetch address (held until granted)
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order response, at least one cycle after grant
//   valid_o               output instruction valid
//   fetch_state_o         {pc, next_pc} of inst_o
//   inst_o                instruction to decode

typedef struct packed {
  logic stall;
  logic squash;
} stage_ctrl_t;

typedef struct packed {
  logic [31:0] pc;
  logic [31:0] next_pc;
} fetch_state_t;

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  stage_ctrl_t  stage_ctrl_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic         valid_o,
  output fetch_state_t fetch_state_o,
  output logic [31:0]  inst_o
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;     // requests granted, response not yet seen
  logic [CNT_W-1:0] disc_q, disc_d;   // in-flight responses belonging to a flushed path
  logic [CNT_W-1:0] cnt_q, cnt_d;     // response-buffer occupancy
  logic [PTR_W-1:0] pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;
  logic [PTR_W-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic             valid_q, valid_d;
  fetch_state_t     fs_q, fs_d;
  logic [31:0]      inst_q, inst_d;

  logic [31:0] pcf_mem_q  [BUF_DEPTH];
  logic [31:0] buf_pc_q   [BUF_DEPTH];
  logic [31:0] buf_inst_q [BUF_DEPTH];

  logic        gnt, rsp_live, rsp_drop, upd, pop, bypass, push;
  logic [31:0] rsp_pc, redir_pc, head_pc;

  // Credits cover both in-flight requests and buffered responses, so every
  // response that returns always has a buffer slot waiting for it.
  assign imem_req_o  = !rst_i && !redirect_i &&
                       (({1'b0, out_q} + {1'b0, cnt_q}) < CREDITS);
  assign imem_addr_o = pc_q;

  assign gnt      = imem_req_o && imem_gnt_i;
  assign rsp_drop = imem_rvalid_i && (disc_q != '0);
  assign rsp_live = imem_rvalid_i && (disc_q == '0);
  assign upd      = !stage_ctrl_i.stall;
  assign pop      = !redirect_i && upd && (cnt_q != '0);
  // A response that finds the buffer empty and decode ready skips the buffer.
  assign bypass   = !redirect_i && upd && (cnt_q == '0) && rsp_live;
  assign push     = !redirect_i && rsp_live && !bypass;
  assign rsp_pc   = pcf_mem_q[pcf_rd_q];
  assign head_pc  = buf_pc_q[buf_rd_q];
  assign redir_pc = redirect_pc_i & ~32'h0000_0003;

  assign valid_o       = valid_q;
  assign fetch_state_o = fs_q;
  assign inst_o        = inst_q;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q;
    disc_d   = disc_q;
    cnt_d    = cnt_q;
    pcf_rd_d = pcf_rd_q;
    pcf_wr_d = pcf_wr_q;
    buf_rd_d = buf_rd_q;
    buf_wr_d = buf_wr_q;
    valid_d  = valid_q;
    fs_d     = fs_q;
    inst_d   = inst_q;

    if (gnt && !imem_rvalid_i) begin
      out_d = out_q + CNT_ONE;
    end else if (!gnt && imem_rvalid_i) begin
      out_d = out_q - CNT_ONE;
    end

    if (redirect_i) begin
      pc_d     = redir_pc;
      // Everything still in flight after this cycle belongs to the old path.
      // Stale responses are dropped without touching the PC FIFO, which is
      // emptied here, so the FIFO only ever holds live requests.
      disc_d   = imem_rvalid_i ? (out_q - CNT_ONE) : out_q;
      pcf_rd_d = '0;
      pcf_wr_d = '0;
      buf_rd_d = '0;
      buf_wr_d = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
    end else begin
      if (gnt) begin
        pc_d     = pc_q + 32'd4;
        pcf_wr_d = pcf_wr_q + PTR_ONE;
      end
      if (rsp_drop) disc_d = disc_q - CNT_ONE;
      if (rsp_live) pcf_rd_d = pcf_rd_q + PTR_ONE;
      if (push) buf_wr_d = buf_wr_q + PTR_ONE;
      if (pop) buf_rd_d = buf_rd_q + PTR_ONE;
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_ONE;
      end

      if (upd) begin
        if (pop) begin
          valid_d      = !stage_ctrl_i.squash;
          fs_d.pc      = head_pc;
          fs_d.next_pc = head_pc + 32'd4;
          inst_d       = buf_inst_q[buf_rd_q];
        end else if (bypass) begin
          valid_d      = !stage_ctrl_i.squash;
          fs_d.pc      = rsp_pc;
          fs_d.next_pc = rsp_pc + 32'd4;
          inst_d       = imem_rdata_i;
        end else begin
          valid_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      pcf_rd_q <= '0;
      pcf_wr_q <= '0;
      buf_rd_q <= '0;
      buf_wr_q <= '0;
      valid_q  <= 1'b0;
      fs_q     <= '0;
      inst_q   <= NOP;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      pcf_rd_q <= pcf_rd_d;
      pcf_wr_q <= pcf_wr_d;
      buf_rd_q <= buf_rd_d;
      buf_wr_q <= buf_wr_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      inst_q   <= inst_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) pcf_mem_q[pcf_wr_q] <= pc_q;
    if (push) begin
      buf_pc_q[buf_wr_q]   <= rsp_pc;
      buf_inst_q[buf_wr_q] <= imem_rdata_i;
    end
  end

  // Overflow means the credit accounting has been broken.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (cnt_q == CNT_FULL)));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  stage_ctrl_t  stage_ctrl_i;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_gnt_i;
  logic         imem_rvalid_i;
  logic [31:0]  imem_rdata_i;
  logic         valid_o;
  fetch_state_t fetch_state_o;
  logic [31:0]  inst_o;

  logic rsp_en;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stage_ctrl_i  (stage_ctrl_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .fetch_state_o (fetch_state_o),
    .inst_o        (inst_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Instruction memory: in-order, one cycle after grant unless rsp_en holds it.
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mq.delete();
    end else begin
      if (imem_rvalid_i && mq.size() > 0) mq.delete(0);
      if (imem_req_o && imem_gnt_i) mq.push_back('{imem_addr_o, cyc + 1});
      cyc++;
    end
  end

  always @(negedge clk_i) begin
    #1;
    if (!rst_i && rsp_en && mq.size() > 0 && mq[0].rdy <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
  end

  // Reference model: a queue of in-flight fetches (tagged stale on redirect)
  // and a queue of returned-but-undelivered instructions.
  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  infl_t       infl_q[$];
  logic [31:0] avail_q[$];
  logic [31:0] m_fpc;
  logic        m_valid;
  logic [31:0] m_pc, m_npc, m_inst;

  function automatic bit exp_req();
    return !rst_i && !redirect_i && ((infl_q.size() + avail_q.size()) < BUF_DEPTH);
  endfunction

  always @(posedge clk_i or posedge rst_i) begin : model
    bit          req_now;
    bit          have_r;
    infl_t       r;
    logic [31:0] p;
    if (rst_i) begin
      infl_q.delete();
      avail_q.delete();
      m_fpc   = RESET_PC;
      m_valid = 1'b0;
      m_pc    = '0;
      m_npc   = '0;
      m_inst  = NOP;
    end else begin
      req_now = exp_req();
      have_r  = 1'b0;
      if (imem_rvalid_i && infl_q.size() > 0) begin
        r      = infl_q.pop_front();
        have_r = !r.stale;
      end
      if (redirect_i) begin
        foreach (infl_q[i]) infl_q[i].stale = 1'b1;
        avail_q.delete();
        m_valid = 1'b0;
        m_fpc   = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (have_r) avail_q.push_back(r.pc);
        if (req_now && imem_gnt_i) begin
          infl_q.push_back('{m_fpc, 1'b0});
          m_fpc = m_fpc + 32'd4;
        end
        if (!stage_ctrl_i.stall) begin
          if (avail_q.size() > 0) begin
            p       = avail_q.pop_front();
            m_valid = !stage_ctrl_i.squash;
            m_pc    = p;
            m_npc   = p + 32'd4;
            m_inst  = mem_word(p);
          end else begin
            m_valid = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    #1;
    chk("req", {31'b0, imem_req_o}, {31'b0, exp_req()});
    if (exp_req()) chk("addr", imem_addr_o, m_fpc);
    chk("valid", {31'b0, valid_o}, {31'b0, m_valid});
    chk("pc", fetch_state_o.pc, m_pc);
    chk("next_pc", fetch_state_o.next_pc, m_npc);
    chk("inst", inst_o, m_inst);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    stage_ctrl_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    rsp_en        = 1'b1;
    #2 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Straight-line fetch
    @(negedge clk_i); #2;
    chk("lit_e1_valid", {31'b0, valid_o}, 32'd0);
    chk("lit_e1_addr", imem_addr_o, 32'h4);
    @(negedge clk_i); #2;
    chk("lit_e2_valid", {31'b0, valid_o}, 32'd1);
    chk("lit_e2_pc", fetch_state_o.pc, 32'h0);
    chk("lit_e2_inst", inst_o, 32'h1357_9BDF);
    @(negedge clk_i);
    stage_ctrl_i.stall = 1'b1;
    #2;
    chk("lit_e3_pc", fetch_state_o.pc, 32'h4);
    chk("lit_e3_npc", fetch_state_o.next_pc, 32'h8);

    // Decode stall with two responses in flight
    @(negedge clk_i); #2;
    chk("lit_stall_req0", {31'b0, imem_req_o}, 32'd0);
    @(negedge clk_i); #2;
    chk("lit_stall_req1", {31'b0, imem_req_o}, 32'd0);
    chk("lit_stall_frozen", fetch_state_o.pc, 32'h4);
    @(negedge clk_i);
    stage_ctrl_i.stall = 1'b0;
    #2;
    chk("lit_stall_valid", {31'b0, valid_o}, 32'd1);
    @(negedge clk_i); #2;
    chk("lit_rel_pc8", fetch_state_o.pc, 32'h8);
    @(negedge clk_i);
    stage_ctrl_i.squash = 1'b1;
    #2;
    chk("lit_rel_pcC", fetch_state_o.pc, 32'hC);

    // Squash consumes pc 0x10
    @(negedge clk_i);
    stage_ctrl_i.squash = 1'b0;
    #2;
    chk("lit_sq_valid", {31'b0, valid_o}, 32'd0);
    chk("lit_sq_pc", fetch_state_o.pc, 32'h10);
    @(negedge clk_i); #2;
    chk("lit_sq_next", fetch_state_o.pc, 32'h14);
    chk("lit_sq_next_v", {31'b0, valid_o}, 32'd1);

    // Redirect to 0x100 with two requests outstanding
    @(negedge clk_i);
    rsp_en = 1'b0;
    #2;
    chk("lit_pc18", fetch_state_o.pc, 32'h18);
    @(negedge clk_i); #2;
    chk("lit_hold_valid", {31'b0, valid_o}, 32'd0);
    @(negedge clk_i);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    #2;
    chk("lit_redir_req", {31'b0, imem_req_o}, 32'd0);
    @(negedge clk_i);
    redirect_i = 1'b0;
    rsp_en     = 1'b1;
    #2;
    chk("lit_redir_valid", {31'b0, valid_o}, 32'd0);
    chk("lit_redir_nocredit", {31'b0, imem_req_o}, 32'd0);
    @(negedge clk_i); #2;
    chk("lit_redir_addr", imem_addr_o, 32'h100);
    @(negedge clk_i); #2;
    chk("lit_stale_dropped", {31'b0, valid_o}, 32'd0);
    @(negedge clk_i); #2;
    chk("lit_new_valid", {31'b0, valid_o}, 32'd1);
    chk("lit_new_pc", fetch_state_o.pc, 32'h100);
    chk("lit_new_inst", inst_o, 32'h1357_9ADF);

    // Misaligned redirect coinciding with a response, then PC wrap
    @(negedge clk_i);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    #2;
    @(negedge clk_i);
    redirect_i = 1'b0;
    #2;
    chk("lit_wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk_i); #2;
    chk("lit_wrap_pc0", imem_addr_o, 32'h0);
    @(negedge clk_i); #2;
    chk("lit_wrap_valid", {31'b0, valid_o}, 32'd1);
    chk("lit_wrap_pc", fetch_state_o.pc, 32'hFFFF_FFFC);
    chk("lit_wrap_npc", fetch_state_o.next_pc, 32'h0);
    chk("lit_wrap_inst", inst_o, 32'hECA8_6423);
    @(negedge clk_i); #2;
    chk("lit_after_wrap", fetch_state_o.pc, 32'h0);

    // Async reset mid-stall with two outstanding
    @(negedge clk_i);
    stage_ctrl_i.stall = 1'b1;
    rsp_en = 1'b0;
    @(negedge clk_i); #2;
    chk("lit_rs_req", {31'b0, imem_req_o}, 32'd0);
    @(negedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("lit_rst_valid", {31'b0, valid_o}, 32'd0);
    chk("lit_rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("lit_rst_inst", inst_o, NOP);
    @(negedge clk_i);
    rst_i = 1'b0;
    stage_ctrl_i.stall = 1'b0;
    rsp_en = 1'b1;
    #2;
    chk("lit_rel_req", {31'b0, imem_req_o}, 32'd1);
    chk("lit_rel_addr", imem_addr_o, RESET_PC);
    repeat (2) @(negedge clk_i);
    #2;
    chk("lit_rel_first", fetch_state_o.pc, RESET_PC);
    chk("lit_rel_first_v", {31'b0, valid_o}, 32'd1);
    repeat (3) @(negedge clk_i);
    #2;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
